// File: rtl/hazard_sched.sv
// hazard_sched: pipeline hazard controller for the 5-stage MIPS datapath.
// It sequences front-end hold and flush for load-use hazards and taken branches.
// It also runs the issue/wait/complete handshake of the multi-cycle mul/div unit.
module hazard_sched #(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_md,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             md_go,
    output logic             md_abort,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic S_RUN     = 1'b0;
    localparam logic S_MD_WAIT = 1'b1;

    localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

    logic       state, state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic       lu;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    always_comb begin
        lu = ex_memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    // Mealy output and next-state decode, forced to pass-through during reset.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_go       = 1'b0;
        md_abort    = 1'b0;
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        if (rst_n) begin
            case (state)
                S_RUN: begin
                    if (mem_br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (lu) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end else if (id_is_md) begin
                        md_go      = 1'b1;
                        md_cnt_nxt = MD_INIT;
                        state_nxt  = S_MD_WAIT;
                    end
                end
                default: begin
                    if (mem_br_taken) begin
                        md_abort    = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        md_cnt_nxt  = 4'd0;
                        state_nxt   = S_RUN;
                    end else begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        md_cnt_nxt = md_cnt - 4'd1;
                        if (md_cnt == 4'd1) begin
                            state_nxt = S_RUN;
                        end
                    end
                end
            endcase
        end
    end

    // md_busy reflects the wait state, masked while reset is asserted.
    always_comb begin
        md_busy = rst_n && (state == S_MD_WAIT);
    end

    // State, mul/div countdown and saturating stall counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_RUN;
            md_cnt    <= 4'd0;
            stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed-vector bench for hazard_sched (MD_LAT=4, CNT_W=4).
module tb_hazard_sched;

    localparam int unsigned CNT_W = 4;

    // Packed outputs: {pc_write, ifid_write, ifid_flush, idex_flush,
    //                  exmem_flush, md_go, md_abort, md_busy}
    localparam logic [7:0] O_DEF   = 8'b1100_0000;
    localparam logic [7:0] O_STALL = 8'b0001_0000;
    localparam logic [7:0] O_FLUSH = 8'b1111_1000;
    localparam logic [7:0] O_GO    = 8'b1100_0100;
    localparam logic [7:0] O_MDWT  = 8'b0001_0001;
    localparam logic [7:0] O_ABORT = 8'b1111_1011;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, id_is_md, ex_memread, mem_br_taken;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic             md_go, md_abort, md_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       outs;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    hazard_sched #(.MD_LAT(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_is_md     (id_is_md),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .mem_br_taken (mem_br_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .md_go        (md_go),
        .md_abort     (md_abort),
        .md_busy      (md_busy),
        .stall_cnt    (stall_cnt)
    );

    assign outs = {pc_write, ifid_write, ifid_flush, idex_flush,
                   exmem_flush, md_go, md_abort, md_busy};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check the Mealy outputs, then take the edge.
    task automatic vec(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic md, input logic mr,
                       input logic [4:0] ert, input logic br, input logic [7:0] exp);
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = ur;
        id_is_md     = md;
        ex_memread   = mr;
        ex_rt        = ert;
        mem_br_taken = br;
        #1;
        chk(tag, {24'd0, outs}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic cnt(input string tag, input int unsigned exp);
        chk(tag, {{(32-CNT_W){1'b0}}, stall_cnt}, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        // Reset with a live hazard and a branch: outputs must stay pass-through.
        vec("rst_outs", 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, O_DEF);
        cnt("rst_cnt", 0);
        rst_n = 1'b1;
        vec("idle", 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, O_DEF);

        // Load-use on rs: one stall cycle, then the load has moved on.
        vec("lu_rs", 5'd8, 5'd2, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, O_STALL);
        vec("lu_rs_after", 5'd8, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_DEF);
        cnt("cnt_lu", 1);
        vec("lu_r0", 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, O_DEF);
        vec("lu_miss", 5'd7, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, O_DEF);
        vec("lu_noload", 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, O_DEF);
        cnt("cnt_r0", 1);

        // rt-only dependence, gated by id_uses_rt.
        vec("lu_rt_used", 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, O_STALL);
        vec("lu_rt_unused", 5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, O_DEF);
        cnt("cnt_rt", 2);

        // Branch beats load-use and mul/div issue.
        vec("br_lu", 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, O_FLUSH);
        vec("br_md", 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, O_FLUSH);
        vec("br_after", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_DEF);
        cnt("cnt_br", 2);

        // Mul/div: go, three wait cycles (LU ignored inside), back to RUN.
        vec("md_go", 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, O_GO);
        vec("md_w1", 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, O_MDWT);
        vec("md_w2_lu", 5'd4, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, O_MDWT);
        vec("md_w3", 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, O_MDWT);
        vec("md_done", 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, O_DEF);
        cnt("cnt_md", 5);

        // Mul/div arriving behind a load-use: stall first, issue next cycle.
        vec("lu_md", 5'd6, 5'd2, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, O_STALL);
        vec("lu_md_go", 5'd6, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, O_GO);
        vec("lu_md_w1", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_MDWT);
        vec("lu_md_w2", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_MDWT);
        vec("lu_md_w3", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_MDWT);
        vec("lu_md_done", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_DEF);
        cnt("cnt_lu_md", 9);

        // Abort on the second wait cycle.
        vec("ab_go", 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, O_GO);
        vec("ab_w1", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_MDWT);
        vec("ab_abort", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, O_ABORT);
        vec("ab_run", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_DEF);
        cnt("cnt_abort", 10);

        // Reset in the middle of MD_WAIT: no abort, counter cleared.
        vec("rw_go", 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, O_GO);
        vec("rw_w1", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_MDWT);
        cnt("cnt_rw_pre", 11);
        rst_n = 1'b0;
        vec("rw_rst", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_DEF);
        rst_n = 1'b1;
        cnt("cnt_rw", 0);
        vec("rw_run", 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_DEF);

        // Saturation: hold the hazard for 20 cycles; counter stops at 15.
        for (int i = 0; i < 20; i++) begin
            vec("sat_stall", 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, O_STALL);
            cnt("sat_cnt", (i + 1 < 15) ? i + 1 : 15);
        end
        vec("sat_release", 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_DEF);
        cnt("sat_hold", 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
